// File: rtl/pn_scr_pkg.sv
// Shared constants and helpers for the PN scrambler channel.
package pn_scr_pkg;

  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SS   = 1'b1;
  localparam logic DIR_SCR   = 1'b0;
  localparam logic DIR_DESCR = 1'b1;

  // x^8 + x^4 + x^3 + x^2 + 1
  localparam int         DEF_L    = 8;
  localparam logic [7:0] DEF_TAPS = 8'h8E;
  localparam logic [7:0] DEF_SEED = 8'hFF;

  typedef logic [15:0] beat_cnt_t;
  localparam beat_cnt_t CNT_MAX = 16'hFFFF;

  // Feedback bit of the LFSR: parity of the tapped state bits.
  function automatic logic lfsr_next_bit(input logic [31:0] s, input logic [31:0] taps);
    return ^(s & taps);
  endfunction

endpackage

// File: rtl/pn_lfsr_unroll.sv
// Combinational DW-bit unrolled LFSR step, MSB processed first.
module pn_lfsr_unroll import pn_scr_pkg::*; #(
  parameter int             DW   = 8,
  parameter int             L    = DEF_L,
  parameter logic [L-1:0]   TAPS = DEF_TAPS
) (
  input  logic [L-1:0]  s,
  input  logic [DW-1:0] d,
  input  logic          mode,
  input  logic          dir,
  output logic [DW-1:0] o,
  output logic [L-1:0]  s_next
);

  logic [L-1:0] st;
  logic         fb;
  logic         ob;
  logic         feed;

  // Walk the beat bit by bit; the shift-in bit depends on mode and direction.
  always_comb begin
    st   = s;
    fb   = 1'b0;
    ob   = 1'b0;
    feed = 1'b0;
    o    = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = lfsr_next_bit(32'(st), 32'(TAPS));
      if (mode == MODE_SS) begin
        ob   = d[i] ^ fb;
        feed = (dir == DIR_DESCR) ? d[i] : ob;
      end else begin
        ob   = d[i] ^ st[L-1];
        feed = fb;
      end
      st   = {st[L-2:0], feed};
      o[i] = ob;
    end
    s_next = st;
  end

endmodule

// File: rtl/pn_scrambler_chan.sv
// Byte-parallel PN scrambler/descrambler channel with a 1-deep output register.
module pn_scrambler_chan import pn_scr_pkg::*; #(
  parameter int           DW   = 8,
  parameter int           L    = DEF_L,
  parameter logic [L-1:0] TAPS = DEF_TAPS,
  parameter logic [L-1:0] SEED = DEF_SEED
) (
  input  logic          clk_40M,
  input  logic          rst,
  input  logic          cfg_mode,
  input  logic          cfg_dir,
  input  logic          seed_load,
  input  logic [L-1:0]  seed_val,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic [15:0]   beat_cnt
);

  logic          accept;
  logic [L-1:0]  lfsr_q;
  logic [L-1:0]  s_cur;
  logic [L-1:0]  s_next;
  logic [DW-1:0] o_beat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Reload mux: seed_val beats an additive-mode SOF, and the reloaded state feeds this beat.
  always_comb begin
    s_cur = lfsr_q;
    if (seed_load)
      s_cur = seed_val;
    else if (accept && in_sof && (cfg_mode == MODE_ADD))
      s_cur = SEED;
  end

  pn_lfsr_unroll #(
    .DW   (DW),
    .L    (L),
    .TAPS (TAPS)
  ) u_unroll (
    .s      (s_cur),
    .d      (in_data),
    .mode   (cfg_mode),
    .dir    (cfg_dir),
    .o      (o_beat),
    .s_next (s_next)
  );

  // LFSR state and beat counter; the state only moves on accepted beats or seed loads.
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      lfsr_q   <= SEED;
      beat_cnt <= '0;
    end else begin
      if (accept)
        lfsr_q <= s_next;
      else if (seed_load)
        lfsr_q <= seed_val;

      if (seed_load)
        beat_cnt <= accept ? 16'd1 : 16'd0;
      else if (accept && (beat_cnt != CNT_MAX))
        beat_cnt <= beat_cnt + 16'd1;
    end
  end

  // Output register: loads on accept, holds while stalled, drains when consumed.
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= o_beat;
      out_sof   <= in_sof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pn_scrambler_chan.sv
`timescale 1ns/1ps
// Directed bench for pn_scrambler_chan: instance A is the main DUT, instance B the far-end partner.
module tb_pn_scrambler_chan;

  logic clk_40M = 1'b0;
  logic rst     = 1'b1;

  logic        a_cfg_mode = 0, a_cfg_dir = 0, a_seed_load = 0;
  logic [7:0]  a_seed_val = 0;
  logic        a_in_valid = 0, a_in_sof = 0, a_out_ready = 1;
  logic [7:0]  a_in_data = 0;
  logic        a_in_ready, a_out_valid, a_out_sof;
  logic [7:0]  a_out_data;
  logic [15:0] a_beat_cnt;

  logic        b_cfg_mode = 0, b_cfg_dir = 0, b_seed_load = 0;
  logic [7:0]  b_seed_val = 0;
  logic        b_in_valid = 0, b_in_sof = 0, b_out_ready = 1;
  logic [7:0]  b_in_data = 0;
  logic        b_in_ready, b_out_valid, b_out_sof;
  logic [7:0]  b_out_data;
  logic [15:0] b_beat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rnd [64];
  logic [7:0] scr [64];
  logic [7:0] ks  [16];
  logic [7:0] dat [16];
  logic [7:0] expd[16];

  always #12.5 clk_40M = ~clk_40M;

  pn_scrambler_chan u_a (
    .clk_40M(clk_40M), .rst(rst), .cfg_mode(a_cfg_mode), .cfg_dir(a_cfg_dir),
    .seed_load(a_seed_load), .seed_val(a_seed_val), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .in_sof(a_in_sof),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sof(a_out_sof), .beat_cnt(a_beat_cnt)
  );

  pn_scrambler_chan u_b (
    .clk_40M(clk_40M), .rst(rst), .cfg_mode(b_cfg_mode), .cfg_dir(b_cfg_dir),
    .seed_load(b_seed_load), .seed_val(b_seed_val), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .in_sof(b_in_sof),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sof(b_out_sof), .beat_cnt(b_beat_cnt)
  );

  task automatic tick();
    @(posedge clk_40M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Keystream of x^8+x^4+x^3+x^2+1 (bit 7 out first, taps at bits 7,3,2,1).
  task automatic gen_ks(input logic [7:0] seed);
    logic [7:0] s;
    logic       f;
    s = seed;
    for (int j = 0; j < 16; j++) begin
      for (int b = 7; b >= 0; b--) begin
        ks[j][b] = s[7];
        f = s[7] ^ s[3] ^ s[2] ^ s[1];
        s = {s[6:0], f};
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  idx;
    int  got;
    logic stalled;
    logic [7:0] held;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data",  32'(a_out_data),  32'h00);
    check("rst_out_sof",   32'(a_out_sof),   32'd0);
    check("rst_beat_cnt",  32'(a_beat_cnt),  32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);

    // T1: additive from SEED 0xFF, zero data
    a_in_valid = 1; a_in_data = 8'h00; a_in_sof = 1;
    tick();
    check("t1_b0_valid", 32'(a_out_valid), 32'd1);
    check("t1_b0_data",  32'(a_out_data),  32'hFF);
    check("t1_b0_sof",   32'(a_out_sof),   32'd1);
    check("t1_b0_cnt",   32'(a_beat_cnt),  32'd1);
    a_in_sof = 0;
    tick();
    check("t1_b1_data",  32'(a_out_data),  32'h21);
    check("t1_b1_sof",   32'(a_out_sof),   32'd0);
    check("t1_b1_cnt",   32'(a_beat_cnt),  32'd2);
    tick();
    check("t1_b2_data",  32'(a_out_data),  32'h4F);
    check("t1_b2_cnt",   32'(a_beat_cnt),  32'd3);
    a_in_sof = 1;
    tick();
    check("sof_reload_data", 32'(a_out_data), 32'hFF);
    check("sof_reload_cnt",  32'(a_beat_cnt), 32'd4);
    a_in_valid = 0; a_in_sof = 0;
    tick();
    check("drain_valid", 32'(a_out_valid), 32'd0);

    // T5: seed_load with a concurrent accepted beat
    a_seed_load = 1; a_seed_val = 8'h5A; a_in_valid = 1; a_in_data = 8'h00;
    tick();
    check("t5_data", 32'(a_out_data), 32'h5A);
    check("t5_cnt",  32'(a_beat_cnt), 32'd1);
    a_in_sof = 1; a_in_data = 8'h0F;
    tick();
    check("seed_over_sof_data", 32'(a_out_data), 32'h55);
    check("seed_over_sof_cnt",  32'(a_beat_cnt), 32'd1);
    a_seed_load = 0; a_in_sof = 0; a_in_valid = 0;
    tick();
    a_seed_load = 1; a_seed_val = 8'h21;
    tick();
    a_seed_load = 0;
    check("seed_idle_cnt", 32'(a_beat_cnt), 32'd0);
    a_in_valid = 1; a_in_data = 8'h00;
    tick();
    check("seed_idle_data", 32'(a_out_data), 32'h21);
    check("seed_idle_cnt1", 32'(a_beat_cnt), 32'd1);
    a_in_valid = 0;
    tick();

    // Self-sync hand vectors from seed 0xFF, zero data
    a_cfg_mode = 1; a_cfg_dir = 0; a_seed_load = 1; a_seed_val = 8'hFF; a_in_valid = 1; a_in_data = 8'h00;
    tick();
    check("ss_scr_data", 32'(a_out_data), 32'h21);
    a_cfg_dir = 1;
    tick();
    check("ss_descr_data", 32'(a_out_data), 32'h2F);
    a_cfg_dir = 0; a_seed_val = 8'h00; a_in_valid = 0;
    tick();
    a_seed_load = 0; a_in_valid = 1; a_in_sof = 1;
    tick();
    check("ss_sof_no_reload", 32'(a_out_data), 32'h00);
    check("ss_sof_pass",      32'(a_out_sof),  32'd1);
    a_in_valid = 0; a_in_sof = 0;
    tick();

    // T3: self-sync scrambler (seed FF) into descrambler (seed 00)
    a_cfg_mode = 1; a_cfg_dir = 0; a_seed_load = 1; a_seed_val = 8'hFF;
    b_cfg_mode = 1; b_cfg_dir = 1; b_seed_load = 1; b_seed_val = 8'h00;
    tick();
    a_seed_load = 0; b_seed_load = 0;
    for (int j = 0; j < 32; j++) rnd[j] = 8'($urandom);
    for (int j = 0; j < 32; j++) begin
      a_in_valid = 1; a_in_data = rnd[j];
      tick();
      scr[j] = a_out_data;
    end
    a_in_valid = 0;
    for (int j = 0; j < 32; j++) begin
      b_in_valid = 1; b_in_data = scr[j];
      tick();
      if (j > 0) check($sformatf("t3_byte%0d", j), 32'(b_out_data), 32'(rnd[j]));
    end
    b_in_valid = 0;
    tick();

    // T2: additive scrambler into additive descrambler, SOF on byte 0
    a_cfg_mode = 0; b_cfg_mode = 0; b_cfg_dir = 0;
    for (int j = 0; j < 64; j++) rnd[j] = 8'($urandom);
    for (int j = 0; j < 64; j++) begin
      a_in_valid = 1; a_in_data = rnd[j]; a_in_sof = (j == 0);
      tick();
      scr[j] = a_out_data;
    end
    a_in_valid = 0; a_in_sof = 0;
    for (int j = 0; j < 64; j++) begin
      b_in_valid = 1; b_in_data = scr[j]; b_in_sof = (j == 0);
      tick();
      check($sformatf("t2_byte%0d", j), 32'(b_out_data), 32'(rnd[j]));
    end
    b_in_valid = 0; b_in_sof = 0;
    tick();

    // T4: backpressure with out_ready toggling 1010...
    a_seed_load = 1; a_seed_val = 8'hFF;
    tick();
    a_seed_load = 0;
    gen_ks(8'hFF);
    for (int j = 0; j < 16; j++) begin
      dat[j]  = 8'($urandom);
      expd[j] = dat[j] ^ ks[j];
    end
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      a_out_ready = ((cyc % 2) == 0);
      a_in_valid  = (idx < 16);
      a_in_data   = (idx < 16) ? dat[idx] : 8'h00;
      a_in_sof    = (idx == 0);
      #1;
      if (a_out_valid && a_out_ready) begin
        check($sformatf("t4_data%0d", got), 32'(a_out_data), 32'(expd[got]));
        check($sformatf("t4_sof%0d", got),  32'(a_out_sof),  32'(got == 0));
        got++;
      end
      stalled = a_out_valid && !a_out_ready;
      held    = a_out_data;
      if (stalled) check("t4_in_ready_stall", 32'(a_in_ready), 32'd0);
      if (a_in_valid && a_in_ready) idx++;
      tick();
      if (stalled) begin
        check("t4_hold_valid", 32'(a_out_valid), 32'd1);
        check("t4_hold_data",  32'(a_out_data),  32'(held));
      end
    end
    check("t4_beats_out", 32'(got), 32'd16);
    check("t4_beats_in",  32'(idx), 32'd16);
    check("t4_cnt",       32'(a_beat_cnt), 32'd16);
    a_in_valid = 0; a_in_sof = 0; a_out_ready = 1;
    tick();

    // T6: reset mid-stream with a stalled output beat
    a_in_valid = 1; a_in_data = 8'h00; a_in_sof = 1; a_out_ready = 0;
    tick();
    check("t6_pre_valid", 32'(a_out_valid), 32'd1);
    a_in_valid = 0; a_in_sof = 0;
    tick();
    rst = 1;
    tick();
    check("t6_rst_valid", 32'(a_out_valid), 32'd0);
    check("t6_rst_cnt",   32'(a_beat_cnt),  32'd0);
    check("t6_rst_data",  32'(a_out_data),  32'h00);
    rst = 0; a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h00;
    tick();
    check("t6_b0_data", 32'(a_out_data), 32'hFF);
    tick();
    check("t6_b1_data", 32'(a_out_data), 32'h21);
    a_in_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
